// File: rtl/psum_ofifo_pkg.sv
// Shared constants for the psum output FIFO.
// Default geometry and the pointer width helper (wrap bit included).
package psum_ofifo_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 64;

  // Pointer carries one extra MSB used as the wrap bit.
  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int PTR_W = ptr_w(DEPTH);

endpackage

// File: rtl/psum_ofifo_col_fifo.sv
// Single-column circular psum buffer with wrap-bit full/empty.
// Ports: clk, reset, wr, rd, din -> full, empty, head.
module col_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [psum_bw-1:0] head
);

  localparam int PW = ptr_w(depth);
  localparam int AW = PW - 1;

  logic [psum_bw-1:0] mem [depth];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic               wr_ok;
  logic               rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign head  = mem[rptr[AW-1:0]];

  // Both decisions use pre-edge pointers.
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; pointers define contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Re-aligns skewed per-column psums into whole rows for the SFU.
// Ports: clk, reset, in, wr, rd -> o_full, o_ready, o_valid, out
// (+ sticky o_err when PSUM_OFIFO_ERR_EN is defined).
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid,
`ifdef PSUM_OFIFO_ERR_EN
  output logic                   o_err,
`endif
  output logic [psum_bw*col-1:0] out
);

  logic [col-1:0]         full;
  logic [col-1:0]         empty;
  logic [psum_bw*col-1:0] heads;
  logic                   rd_acc;

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = !o_full;
  // Lock-step pop keeps the columns row-aligned.
  assign rd_acc  = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    col_fifo #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[c]),
      .rd    (rd_acc),
      .din   (in[psum_bw*c +: psum_bw]),
      .full  (full[c]),
      .empty (empty[c]),
      .head  (heads[psum_bw*c +: psum_bw])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (rd_acc) begin
      out <= heads;
    end
  end

`ifdef PSUM_OFIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err <= 1'b0;
    end else if ((|(wr & full)) || (rd && !o_valid)) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule
